// File: rtl/load_store_unit.sv
// Load/store unit between datapath and a word-wide data memory; sub-word stores via read-modify-write.
// Latency: load/SW 2 cycles, SB/SH 3 cycles, error 1 cycle to resp_valid; one request in flight (req_ready only in IDLE).
// Optional LSU_PERF_CNT_EN adds wrapping load/store/error counters.
module load_store_unit #(
    parameter int MEM_WORDS = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] load_count,
    output logic [CNT_WIDTH-1:0] store_count,
    output logic [CNT_WIDTH-1:0] err_count
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

    state_t      state, next_state;
    logic        write_q, signed_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        accept, req_err, mem_wr;
    logic [4:0]  sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val, merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                           req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])            req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))   req_err = 1'b1;
    end

    // Lane extraction and merge work on the registered address.
    assign sh     = {addr_q[1:0], 3'b000};
    assign lane_b = ReadData[sh +: 8];
    assign lane_h = addr_q[1] ? ReadData[31:16] : ReadData[15:0];

    always_comb begin
        load_val = ReadData;
        merged   = ReadData;
        case (size_q)
            2'b00: begin
                load_val = {{24{signed_q & lane_b[7]}}, lane_b};
                merged   = (ReadData & ~(32'h0000_00FF << sh)) | ({24'h0, data_q[7:0]} << sh);
            end
            2'b01: begin
                load_val = {{16{signed_q & lane_h[15]}}, lane_h};
                merged   = (ReadData & ~(32'h0000_FFFF << sh)) | ({16'h0, data_q[15:0]} << sh);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        MemRead    = 1'b0;
        mem_wr     = 1'b0;
        Address    = 32'h0;
        WriteData  = 32'h0;
        resp_valid = 1'b0;
        resp_error = 1'b0;
        resp_rdata = 32'h0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err)                   next_state = S_RESP;
                    else if (!req_write)           next_state = S_RD;
                    else if (req_size == 2'b10)    next_state = S_WR;
                    else                           next_state = S_RMW_RD;
                end
            end
            S_RD: begin
                MemRead    = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                next_state = S_RESP;
            end
            S_RMW_RD: begin
                MemRead    = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                next_state = S_WR;
            end
            S_WR: begin
                mem_wr     = 1'b1;
                Address    = {addr_q[31:2], 2'b00};
                WriteData  = data_q;
                next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (!write_q && !err_q) ? data_q : 32'h0;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Reset must suppress a write already in progress in the same cycle.
    assign MemWrite = mem_wr && rst_n;

    // data_q holds store data, then the merged word (RMW) or the extended load result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
        end else if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            err_q    <= req_err;
            size_q   <= req_size;
            addr_q   <= req_addr;
            data_q   <= req_write ? req_wdata : 32'h0;
        end else if (state == S_RD) begin
            data_q   <= load_val;
        end else if (state == S_RMW_RD) begin
            data_q   <= merged;
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_count  <= '0;
            store_count <= '0;
            err_count   <= '0;
        end else if (state == S_RESP) begin
            if (err_q)        err_count   <= err_count + 1'b1;
            else if (write_q) store_count <= store_count + 1'b1;
            else              load_count  <= load_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver queues expected responses, monitor checks them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] Address, WriteData, ReadData;
`ifdef LSU_PERF_CNT_EN
    logic [15:0] load_count, store_count, err_count;
`endif

    load_store_unit #(.MEM_WORDS(256), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
`ifdef LSU_PERF_CNT_EN
        , .load_count(load_count), .store_count(store_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    assign ReadData = mem[Address[9:2]];
    always @(posedge clk) if (MemWrite) mem[Address[9:2]] <= WriteData;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual rdata %h err %b required none", resp_rdata, resp_error);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("resp_error", {31'h0, resp_error}, {31'h0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // kind: 0 load, 1 SW, 2 SB/SH read-modify-write, 3 error
    task automatic do_req(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, input int kind,
                          input logic [31:0] exp_rdata, input logic [31:0] exp_wd);
        int n = 0;
        int lat;
        exp_t e;
        lat = (kind == 2) ? 3 : (kind == 3) ? 1 : 2;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        e.err = (kind == 3); e.rdata = exp_rdata; e.cyc = cyc + lat;
        sbq.push_back(e);
        for (int c = 1; c <= lat; c++) begin
            logic rd, wrc;
            @(negedge clk);
            req_valid = 1'b0;
            rd  = (kind == 0 || kind == 2) && c == 1;
            wrc = (kind == 1 && c == 1) || (kind == 2 && c == 2);
            chk({name, "_MemRead"}, {31'h0, MemRead}, {31'h0, rd});
            chk({name, "_MemWrite"}, {31'h0, MemWrite}, {31'h0, wrc});
            if (rd || wrc) chk({name, "_Address"}, Address, {a[31:2], 2'b00});
            if (wrc) chk({name, "_WriteData"}, WriteData, exp_wd);
        end
        @(negedge clk);
        chk({name, "_ready_after"}, {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h8899AABB;
        mem[8'h11] = 32'h11223344;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
        chk("rst_memctl", {30'h0, MemRead, MemWrite}, 32'h0);

        do_req("LW40",  1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h8899AABB, 32'h0);
        do_req("LB41",  1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 0, 32'hFFFFFFAA, 32'h0);
        do_req("LBU41", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 0, 32'h000000AA, 32'h0);
        do_req("LH42",  1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 0, 32'hFFFF8899, 32'h0);
        do_req("LHU40", 1'b0, 2'b01, 1'b0, 32'h40, 32'h0, 0, 32'h0000AABB, 32'h0);
        do_req("SB43",  1'b1, 2'b00, 1'b0, 32'h43, 32'h12345677, 2, 32'h0, 32'h7799AABB);
        do_req("LW40b", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, 32'h7799AABB, 32'h0);
        do_req("ELH41", 1'b0, 2'b01, 1'b1, 32'h41, 32'h0, 3, 32'h0, 32'h0);
        do_req("ELW42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 3, 32'h0, 32'h0);
        do_req("ESZ11", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 3, 32'h0, 32'h0);
        do_req("ELW400",1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 3, 32'h0, 32'h0);
        do_req("SW48",  1'b1, 2'b10, 1'b0, 32'h48, 32'hCAFEF00D, 1, 32'h0, 32'hCAFEF00D);
        do_req("LW48",  1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 0, 32'hCAFEF00D, 32'h0);
        chk("mem_word12", mem[8'h12], 32'hCAFEF00D);
`ifdef LSU_PERF_CNT_EN
        chk("load_count", {16'h0, load_count}, 32'd7);
        chk("store_count", {16'h0, store_count}, 32'd2);
        chk("err_count", {16'h0, err_count}, 32'd4);
`endif

        // SW aborted by reset asserted during its WR cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h44; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_MemWrite", {31'h0, MemWrite}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("abort_resp_rdata", resp_rdata, 32'h0);
        chk("abort_resp_error", {31'h0, resp_error}, 32'h0);
        chk("abort_mem_word11", mem[8'h11], 32'h11223344);
`ifdef LSU_PERF_CNT_EN
        chk("abort_load_count", {16'h0, load_count}, 32'd0);
`endif
        do_req("LW44", 1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 0, 32'h11223344, 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sbq.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory, between the datapath (multi-cycle control/ALU) and the memory's MemRead/MemWrite/Address/WriteData/ReadData port.
- Accepts one load or store request at a time and supports byte, halfword and word sizes.
- Sub-word loads: extracts the addressed lane and sign/zero-extends it.
- Sub-word stores: read-modify-write over two memory cycles, since the memory only writes whole words.
- Detects misaligned, out-of-range and reserved-size requests and returns an error without touching memory.

Parameters:
- MEM_WORDS, 256, depth of the downstream memory in words; word index >= MEM_WORDS is an error.
- CNT_WIDTH, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted at the edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the lane is taken from the low bits.
- resp_valid  out  1  one-cycle pulse per accepted request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid.
- MemRead  out  1  to data memory.
- MemWrite  out  1  to data memory.
- Address  out  32  to data memory; always word-aligned ({req_addr[31:2],2'b00}).
- WriteData  out  32  to data memory.
- ReadData  in  32  from data memory; combinational, valid in the same cycle as MemRead.

Behaviour:
- Byte lanes are little-endian: byte k occupies bits 8k+7:8k; halfword h occupies bits 16h+15:16h.
- Request fields are registered on acceptance; inputs are ignored while busy.
- States:
  - IDLE: req_ready=1.
  - RD: MemRead=1; capture ReadData at the edge.
  - RMW_RD: MemRead=1; capture ReadData and build the merged word.
  - WR: MemWrite=1; WriteData = merged word or full word.
  - RESP: resp_valid=1.
- Transitions from IDLE on accept:
  - Error → RESP, with resp_error latched to 1.
  - Load → RD.
  - SW → WR.
  - SB/SH → RMW_RD.
  - Then RD→RESP, RMW_RD→WR, WR→RESP, RESP→IDLE.
- Error condition: size==11; or size==01 && addr[0]; or size==10 && addr[1:0]!=0; or addr[31:2] >= MEM_WORDS. On error, MemRead and MemWrite stay 0 throughout.
- Latency (accept edge = N; "cycle k" = cycle after edge N+k-1):
  - Load: MemRead in cycle 1, resp_valid in cycle 2.
  - SW: MemWrite in cycle 1 (write at edge N+1), resp_valid in cycle 2.
  - SB/SH: MemRead in cycle 1, MemWrite in cycle 2, resp_valid in cycle 3.
  - Error: resp_valid in cycle 1.
  - req_ready returns to 1 in the cycle after resp_valid, so back-to-back throughput is one request per 2/3 cycles after the response.
- Outputs to memory are 0 (MemRead, MemWrite, Address, WriteData) in every state except RD, RMW_RD and WR.
- Reset (rst_n low at an edge) forces IDLE and clears all registers:
  - Reset values: resp_valid=0, resp_rdata=0, resp_error=0, req_ready=1 after the reset edge.
  - MemWrite is gated combinationally with rst_n, so a WR cycle coinciding with rst_n low performs no write.
  - The aborted request produces no response.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: adds outputs load_count, store_count and err_count (each CNT_WIDTH).
  - Each increments in the RESP cycle of a completed load, store or error respectively.
  - Counters wrap from all-ones to 0 and clear on reset.
- Undefined: no counter ports or logic; all other behaviour identical.

Test Plan:
- Preload word index 0x10 = 0x8899AABB. LW addr 0x40 → MemRead in cycle 1, resp_valid in cycle 2, resp_rdata 0x8899AABB, resp_error 0.
- Same word:
  - LB signed 0x41 → 0xFFFFFFAA.
  - LBU 0x41 → 0x000000AA.
  - LH signed 0x42 → 0xFFFF8899.
  - LHU 0x40 → 0x0000AABB.
- SB addr 0x43, wdata 0x12345677:
  - MemRead in cycle 1, MemWrite in cycle 2 with WriteData 0x7799AABB, resp_valid in cycle 3.
  - A following LW 0x40 returns 0x7799AABB.
- Error requests: LH 0x41, LW 0x42, size 11, LW 0x400 (index 256) → each gives resp_error=1 and resp_rdata 0 in cycle 1, with MemRead=MemWrite=0 throughout.
- SW 0x44 wdata 0xDEADBEEF with rst_n low on the WR cycle → no write (word 0x11 unchanged), no resp_valid, req_ready=1 after reset. A following LW 0x44 returns the old value.
- With LSU_PERF_CNT_EN: sequence of 3 loads, 2 stores, 1 error → load_count=3, store_count=2, err_count=1. With CNT_WIDTH=2, 4 loads → load_count wraps to 0.
